qk_inst_sequencer: RTL and testbench

- Hardware instruction sequencer driving the fullchip `inst` bus. It replaces hand-stepped per-cycle bench stimulus.
- The host streams Q/K rows through a valid/ready write port, then pulses `start`. The block runs these phases autonomously and signals `done`:
  - K-load,
  - execute,
  - ofifo→pmem drain,
  - optionally, SFP accumulate/divide.
- Sits between host/bench and fullchip. `mem_in` data is routed externally, not through this block.

---
 rtl/qk_inst_sequencer_pkg.sv | 60 ++++++
 rtl/qk_inst_sequencer_if.sv | 29 ++
 rtl/qk_inst_sequencer_phase_cnt.sv | 24 ++
 rtl/qk_inst_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_qk_inst_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/qk_inst_sequencer_pkg.sv
// Shared types for the Q/K instruction sequencer: FSM states, control-flag
// bit positions within the instruction word, and the flag assembly helper.
package qk_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        LOAD_TAIL,
        GAP_A,
        EXEC,
        GAP_B,
        DRAIN,
        SFP,
        DONE
    } state_t;

    // Low control byte of the instruction word; the address fields and the
    // div/acc/ofifo_rd flags sit above it.
    localparam int BIT_PMEM_WR = 0;
    localparam int BIT_PMEM_RD = 1;
    localparam int BIT_KMEM_WR = 2;
    localparam int BIT_KMEM_RD = 3;
    localparam int BIT_QMEM_WR = 4;
    localparam int BIT_QMEM_RD = 5;
    localparam int BIT_LOAD    = 6;
    localparam int BIT_EXECUTE = 7;
    localparam int CTRL_W      = 8;
    localparam int FLAGS_W     = CTRL_W + 3;

    typedef struct packed {
        logic div;
        logic acc;
        logic ofifo_rd;
        logic execute;
        logic load;
        logic qmem_rd;
        logic qmem_wr;
        logic kmem_rd;
        logic kmem_wr;
        logic pmem_rd;
        logic pmem_wr;
    } ctrl_t;

    // Returns {div, acc, ofifo_rd, ctrl_byte}; the caller splices the
    // address fields in between bit 8 and bit 7.
    function automatic logic [FLAGS_W-1:0] ctrl_bits(ctrl_t c);
        logic [CTRL_W-1:0] low;
        low              = '0;
        low[BIT_PMEM_WR] = c.pmem_wr;
        low[BIT_PMEM_RD] = c.pmem_rd;
        low[BIT_KMEM_WR] = c.kmem_wr;
        low[BIT_KMEM_RD] = c.kmem_rd;
        low[BIT_QMEM_WR] = c.qmem_wr;
        low[BIT_QMEM_RD] = c.qmem_rd;
        low[BIT_LOAD]    = c.load;
        low[BIT_EXECUTE] = c.execute;
        return {c.div, c.acc, c.ofifo_rd, low};
    endfunction

endpackage

// File: rtl/qk_inst_sequencer_if.sv
// Host-side bus of the sequencer: run control, Q/K write port, ofifo status
// and the registered instruction word toward fullchip.
interface qk_inst_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 11 + 2 * ADDR_W
);
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   n_q;
    // Write handshake: a row is taken on a cycle where wr_valid and wr_ready
    // are both high; wr_ready never depends on wr_valid.
    logic              wr_valid;
    logic              wr_sel;
    logic              wr_ready;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, n_q, wr_valid, wr_sel, ofifo_valid,
        input  wr_ready, inst, busy, done
    );

    modport slave (
        input  start, abort, n_q, wr_valid, wr_sel, ofifo_valid,
        output wr_ready, inst, busy, done
    );
endinterface

// File: rtl/qk_inst_sequencer_phase_cnt.sv
// Loadable down-counter with terminal-count flag; one instance times every
// phase, another steps the optional SFP micro-sequence.
module qk_seq_phase_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= count - W'(1);
    end

    assign tc = (count == '0);
endmodule

// File: rtl/qk_inst_sequencer.sv
// Autonomous K-load / execute / drain instruction sequencer for fullchip.
// Define SFP_ACC_EN to append the per-row SFP accumulate/divide phase.
module qk_inst_sequencer
    import qk_seq_pkg::*;
#(
    parameter int COL    = 8,
    parameter int ADDR_W = 4,
    parameter int MAX_Q  = 16,
    parameter int GAP    = 10,
    parameter int INST_W = 11 + 2 * ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    qk_inst_sequencer_if.slave   bus,
    output state_t               dbg_state
);
    localparam int MAX_A = (COL + 1 > MAX_Q) ? COL + 1 : MAX_Q;
    localparam int MAX_N = (MAX_A > GAP) ? MAX_A : GAP;
    localparam int CNT_W = $clog2(MAX_N + 1);

    state_t              state, next_state;
    logic [CNT_W-1:0]    cnt, cnt_val, nq_m1, idx_up, load_idx;
    logic                cnt_load, cnt_en, cnt_tc;
    logic [ADDR_W:0]     nq_q, nq_clamped;
    logic [ADDR_W-1:0]   q_ptr, k_ptr, qk_add, p_add;
    logic                wr_ready, wr_fire;
    ctrl_t               ctrl;
    logic [FLAGS_W-1:0]  flags;
    logic [INST_W-1:0]   inst_d;

    assign nq_clamped = (bus.n_q == '0 || bus.n_q > (ADDR_W + 1)'(MAX_Q))
                        ? (ADDR_W + 1)'(MAX_Q) : bus.n_q;
    assign nq_m1    = CNT_W'(nq_q) - CNT_W'(1);
    // Counters run down, so ascending addresses are (length-1) - count.
    assign idx_up   = nq_m1 - cnt;
    assign load_idx = CNT_W'(COL - 1) - cnt;
    assign wr_ready = (state == IDLE) && !bus.start && !reset;
    assign bus.wr_ready = wr_ready;
    assign dbg_state    = state;

    qk_seq_phase_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .count    (cnt),
        .tc       (cnt_tc)
    );

`ifdef SFP_ACC_EN
    logic [2:0] step_cnt, step;
    logic       step_load, step_en, step_tc;

    assign step = 3'd4 - step_cnt;

    qk_seq_phase_cnt #(.W(3)) u_step_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (step_load),
        .load_val (3'd4),
        .en       (step_en),
        .count    (step_cnt),
        .tc       (step_tc)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_en     = 1'b0;
        ctrl       = '0;
        qk_add     = '0;
        p_add      = '0;
        wr_fire    = 1'b0;
`ifdef SFP_ACC_EN
        step_load  = 1'b0;
        step_en    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = LOAD;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(COL);
                end else if (bus.wr_valid && wr_ready) begin
                    wr_fire      = 1'b1;
                    ctrl.kmem_wr = bus.wr_sel;
                    ctrl.qmem_wr = !bus.wr_sel;
                    qk_add       = bus.wr_sel ? k_ptr : q_ptr;
                end
            end
            LOAD: begin
                ctrl.load = 1'b1;
                cnt_en    = 1'b1;
                // First LOAD cycle only raises load; K reads follow.
                if (cnt != CNT_W'(COL)) begin
                    ctrl.kmem_rd = 1'b1;
                    qk_add       = ADDR_W'(load_idx);
                end
                if (cnt_tc)
                    next_state = LOAD_TAIL;
            end
            LOAD_TAIL: begin
                ctrl.load  = 1'b1;
                next_state = GAP_A;
                cnt_load   = 1'b1;
                cnt_val    = CNT_W'(GAP - 1);
            end
            GAP_A: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    next_state = EXEC;
                    cnt_load   = 1'b1;
                    cnt_val    = nq_m1;
                end
            end
            EXEC: begin
                ctrl.execute = 1'b1;
                ctrl.qmem_rd = 1'b1;
                qk_add       = ADDR_W'(idx_up);
                cnt_en       = 1'b1;
                if (cnt_tc) begin
                    next_state = GAP_B;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(GAP - 1);
                end
            end
            GAP_B: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    next_state = DRAIN;
                    cnt_load   = 1'b1;
                    cnt_val    = nq_m1;
                end
            end
            DRAIN: begin
                if (bus.ofifo_valid) begin
                    ctrl.ofifo_rd = 1'b1;
                    ctrl.pmem_wr  = 1'b1;
                    p_add         = ADDR_W'(idx_up);
                    cnt_en        = 1'b1;
                    if (cnt_tc) begin
`ifdef SFP_ACC_EN
                        next_state = SFP;
                        cnt_load   = 1'b1;
                        cnt_val    = nq_m1;
                        step_load  = 1'b1;
`else
                        next_state = DONE;
`endif
                    end
                end
            end
`ifdef SFP_ACC_EN
            SFP: begin
                step_en = 1'b1;
                case (step)
                    3'd0: begin ctrl.pmem_rd = 1'b1; p_add = ADDR_W'(idx_up); end
                    3'd1: ctrl.acc = 1'b1;
                    3'd3: ctrl.div = 1'b1;
                    3'd4: begin ctrl.pmem_wr = 1'b1; p_add = ADDR_W'(idx_up); end
                    default: ;
                endcase
                if (step_tc) begin
                    step_load = 1'b1;
                    cnt_en    = 1'b1;
                    if (cnt_tc)
                        next_state = DONE;
                end
            end
`endif
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (state != IDLE && bus.abort) begin
            next_state = IDLE;
            ctrl       = '0;
            qk_add     = '0;
            p_add      = '0;
        end
    end

    assign flags  = ctrl_bits(ctrl);
    assign inst_d = {flags[FLAGS_W-1:CTRL_W], qk_add, p_add, flags[CTRL_W-1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.inst <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            nq_q     <= '0;
            q_ptr    <= '0;
            k_ptr    <= '0;
        end else begin
            bus.inst <= inst_d;
            bus.busy <= (next_state != IDLE);
            bus.done <= (next_state == DONE);
            if (state == IDLE && bus.start)
                nq_q <= nq_clamped;
            if (state == DONE) begin
                q_ptr <= '0;
                k_ptr <= '0;
            end else if (wr_fire) begin
                if (bus.wr_sel)
                    k_ptr <= k_ptr + ADDR_W'(1);
                else
                    q_ptr <= q_ptr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_qk_inst_sequencer.sv
// Directed and randomized bench for qk_inst_sequencer; expected instruction
// streams come from a phase-level model of the run.
module tb_qk_inst_sequencer;
    import qk_seq_pkg::*;

    localparam int COL    = 8;
    localparam int ADDR_W = 4;
    localparam int MAX_Q  = 16;
    localparam int GAP    = 10;
    localparam int INST_W = 11 + 2 * ADDR_W;

    logic   clk;
    logic   reset;
    state_t dbg_state;

    qk_inst_sequencer_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    qk_inst_sequencer #(
        .COL(COL), .ADDR_W(ADDR_W), .MAX_Q(MAX_Q), .GAP(GAP), .INST_W(INST_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [ADDR_W-1:0] q_ptr, k_ptr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction word built straight from the documented bit map.
    function automatic logic [INST_W-1:0] mk(input bit div, acc, ofr, input int qa, pa,
                                             input bit ex, ld, qrd, qwr, krd, kwr, prd, pwr);
        logic [ADDR_W-1:0] a1, a2;
        a1 = ADDR_W'(qa);
        a2 = ADDR_W'(pa);
        return {div, acc, ofr, a1, a2, ex, ld, qrd, qwr, krd, kwr, prd, pwr};
    endfunction

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.n_q         = '0;
        bus.wr_valid    = 1'b0;
        bus.wr_sel      = 1'b0;
        bus.ofifo_valid = 1'b0;
    endtask

    task automatic do_write(input bit sel);
        bus.start    = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_sel   = sel;
        bus.abort    = 1'($urandom_range(0, 1));
        #1 check("wr_ready_idle", {31'd0, bus.wr_ready}, 32'd1);
        tick();
        if (sel) begin
            check("kmem_wr_inst", bus.inst, mk(0,0,0, k_ptr, 0, 0,0,0,0,0,1,0,0));
            k_ptr = k_ptr + 1'b1;
        end else begin
            check("qmem_wr_inst", bus.inst, mk(0,0,0, q_ptr, 0, 0,0,0,1,0,0,0,0));
            q_ptr = q_ptr + 1'b1;
        end
        bus.wr_valid = 1'b0;
        bus.abort    = 1'b0;
    endtask

    // stall_mode: 0 ofifo always valid, 1 random stalls, 2 three stalls at row 4.
    task automatic run(input int nq_in, input int stall_mode, input int abort_at,
                       input int reset_at, input bit wr_with_start);
        logic [INST_W-1:0] dec[$];
        bit                ov[$];
        int                nq, done_c, r, stalled;
        bit                v, cut, hit_abort;
        nq = (nq_in == 0 || nq_in > MAX_Q) ? MAX_Q : nq_in;
        dec.push_back('0); ov.push_back(1'($urandom_range(0, 1)));
        dec.push_back(mk(0,0,0, 0, 0, 0,1,0,0,0,0,0,0)); ov.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < COL; i++) begin
            dec.push_back(mk(0,0,0, i, 0, 0,1,0,0,1,0,0,0)); ov.push_back(1'($urandom_range(0, 1)));
        end
        dec.push_back(mk(0,0,0, 0, 0, 0,1,0,0,0,0,0,0)); ov.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < GAP; i++) begin
            dec.push_back('0); ov.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < nq; i++) begin
            dec.push_back(mk(0,0,0, i, 0, 1,0,1,0,0,0,0,0)); ov.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < GAP; i++) begin
            dec.push_back('0); ov.push_back(1'($urandom_range(0, 1)));
        end
        r = 0;
        stalled = 0;
        while (r < nq) begin
            if (stall_mode == 2) begin
                v = !(r == 4 && stalled < 3);
                if (!v) stalled++;
            end else if (stall_mode == 1) begin
                v = ($urandom_range(0, 3) != 0);
            end else begin
                v = 1'b1;
            end
            ov.push_back(v);
            if (v) begin
                dec.push_back(mk(0,0,1, 0, r, 0,0,0,0,0,0,0,1));
                r++;
            end else begin
                dec.push_back('0);
            end
        end
`ifdef SFP_ACC_EN
        for (int i = 0; i < nq; i++) begin
            dec.push_back(mk(0,0,0, 0, i, 0,0,0,0,0,0,1,0)); ov.push_back(1'($urandom_range(0, 1)));
            dec.push_back(mk(0,1,0, 0, 0, 0,0,0,0,0,0,0,0)); ov.push_back(1'($urandom_range(0, 1)));
            dec.push_back('0);                               ov.push_back(1'($urandom_range(0, 1)));
            dec.push_back(mk(1,0,0, 0, 0, 0,0,0,0,0,0,0,0)); ov.push_back(1'($urandom_range(0, 1)));
            dec.push_back(mk(0,0,0, 0, i, 0,0,0,0,0,0,0,1)); ov.push_back(1'($urandom_range(0, 1)));
        end
`endif
        done_c = dec.size();
        dec.push_back('0); ov.push_back(1'($urandom_range(0, 1)));

        cut = 1'b0;
        hit_abort = 1'b0;
        for (int c = 0; c <= done_c && !cut; c++) begin
            bus.start = (c == 0) ||
                        (c != abort_at && c != reset_at && $urandom_range(0, 7) == 0);
            bus.n_q         = (c == 0) ? (ADDR_W + 1)'(nq_in) : (ADDR_W + 1)'($urandom_range(0, 31));
            bus.wr_valid    = (c == 0) ? wr_with_start : 1'($urandom_range(0, 1));
            bus.wr_sel      = 1'($urandom_range(0, 1));
            bus.ofifo_valid = ov[c];
            bus.abort       = (c == abort_at);
            reset           = (c == reset_at);
            #1 check("wr_ready_run", {31'd0, bus.wr_ready}, 32'd0);
            tick();
            if (c == abort_at || c == reset_at) begin
                check("cut_inst", bus.inst, '0);
                check("cut_busy", {31'd0, bus.busy}, 32'd0);
                check("cut_done", {31'd0, bus.done}, 32'd0);
                hit_abort = (c == abort_at);
                cut = 1'b1;
            end else begin
                check($sformatf("inst_c%0d", c), bus.inst, dec[c]);
                check($sformatf("busy_c%0d", c), {31'd0, bus.busy}, {31'd0, (c + 1 <= done_c)});
                check($sformatf("done_c%0d", c), {31'd0, bus.done}, {31'd0, (c + 1 == done_c)});
            end
        end
        idle_inputs();
        reset = 1'b0;
        if (!hit_abort) begin
            q_ptr = '0;
            k_ptr = '0;
        end
        for (int i = 0; i < 3; i++) begin
            bus.abort = 1'($urandom_range(0, 1));
            tick();
            check("post_inst", bus.inst, '0);
            check("post_busy", {31'd0, bus.busy}, 32'd0);
            check("post_done", {31'd0, bus.done}, 32'd0);
        end
        bus.abort = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        q_ptr = '0;
        k_ptr = '0;
        tick();
        tick();
        check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
        check("rst_inst", bus.inst, '0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) do_write(1'b0);
        for (int i = 0; i < 8; i++) do_write(1'b1);
        tick();
        check("idle_inst", bus.inst, '0);

        run(8, 0, -1, -1, 1'b0);
        run(8, 2, -1, -1, 1'b0);

        // Reset at EXEC row 3, then pointers restart at 0 and a full run follows.
        do_write(1'b0);
        run(8, 0, -1, 1 + (COL + 1) + 1 + GAP + 3, 1'b0);
        do_write(1'b0);
        run(8, 0, -1, -1, 1'b0);

        // start+wr_valid together rejects the write; abort in GAP_B keeps pointers.
        for (int i = 0; i < 3; i++) do_write(1'b0);
        do_write(1'b1);
        run(8, 0, 1 + (COL + 1) + 1 + GAP + 8 + 3, -1, 1'b1);
        do_write(1'b0);
        do_write(1'b1);

        run(1, 0, -1, -1, 1'b0);
        run(0, 1, -1, -1, 1'b0);
        run(16, 1, -1, -1, 1'b1);
        run(20, 0, -1, -1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            int nw;
            nw = $urandom_range(0, 20);
            for (int i = 0; i < nw; i++) do_write(1'($urandom_range(0, 1)));
            run($urandom_range(0, 20), 1, -1, -1, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
